// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS-subset control path:
// opcode/funct constants, ALU and immediate select codes, FSM state encoding.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_AND   = 3'b010,
    ALU_OR    = 3'b011,
    ALU_SLT   = 3'b100,
    ALU_PASSB = 3'b101
  } alu_op_e;

  typedef enum logic [1:0] {
    IMM_SIGN = 2'b00,
    IMM_ZERO = 2'b01,
    IMM_LUI  = 2'b10
  } imm_sel_e;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    WB_R     = 4'd4,
    WB_I     = 4'd5,
    MEM_ADDR = 4'd6,
    MEM_RD   = 4'd7,
    MEM_WR   = 4'd8,
    WB_MEM   = 4'd9,
    BRANCH   = 4'd10
  } state_e;

  // States that wait on mem_ready and are guarded by the bus timeout.
  function automatic logic is_mem_wait(input state_e s);
    return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Control bus between the multicycle FSM (master) and the datapath/memory (slave).
interface mc_ctrl_fsm_if #(
  parameter int unsigned CNT_W = 32
);
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             zero;
  logic             mem_ready;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             pc_write;
  logic             pc_src;
  logic             iord;
  logic             alu_src_b;
  logic [1:0]       imm_sel;
  logic [2:0]       alu_op;
  logic             reg_write;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             illegal_op;
  logic             bus_err;
  logic [CNT_W-1:0] retired;
  logic [3:0]       state_dbg;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output mem_read, mem_write, ir_write, pc_write, pc_src, iord, alu_src_b,
           imm_sel, alu_op, reg_write, reg_dst, mem_to_reg, illegal_op, bus_err,
           retired, state_dbg
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  mem_read, mem_write, ir_write, pc_write, pc_src, iord, alu_src_b,
           imm_sel, alu_op, reg_write, reg_dst, mem_to_reg, illegal_op, bus_err,
           retired, state_dbg
  );
endinterface

// File: rtl/mc_alu_dec.sv
// Combinational instruction decode: {opcode,funct} -> ALU operation, immediate
// form, ALU B-operand select and legality.
module mc_alu_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output alu_op_e    alu_op,
  output imm_sel_e   imm_sel,
  output logic       alu_src_b,
  output logic       legal
);

  always_comb begin
    alu_op    = ALU_ADD;
    imm_sel   = IMM_SIGN;
    alu_src_b = 1'b0;
    legal     = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          default: legal  = 1'b0;
        endcase
      end
      OP_ADDI: alu_src_b = 1'b1;
      OP_ANDI: begin
        alu_op    = ALU_AND;
        imm_sel   = IMM_ZERO;
        alu_src_b = 1'b1;
      end
      OP_ORI: begin
        alu_op    = ALU_OR;
        imm_sel   = IMM_ZERO;
        alu_src_b = 1'b1;
      end
      OP_SLTI: begin
        alu_op    = ALU_SLT;
        alu_src_b = 1'b1;
      end
      OP_LUI: begin
        alu_op    = ALU_PASSB;
        imm_sel   = IMM_LUI;
        alu_src_b = 1'b1;
      end
      // Address computation: base + sign-extended offset.
      OP_LW, OP_SW: alu_src_b = 1'b1;
      OP_BEQ:       alu_op    = ALU_SUB;
      default:      legal     = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle control FSM for the MIPS-subset datapath, with memory-ready
// timeout, illegal-instruction flag and retired-instruction counter.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15,
  parameter int unsigned CNT_W        = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  mc_ctrl_fsm_if.master bus
);

  state_e           state;
  state_e           state_nxt;
  logic [7:0]       wait_cnt;
  logic             in_wait;
  logic             timeout;
  logic             retire;
  logic [CNT_W-1:0] retired_q;

  alu_op_e          dec_alu_op;
  imm_sel_e         dec_imm_sel;
  logic             dec_src_b;
  logic             dec_legal;

  mc_alu_dec u_alu_dec (
    .opcode    (bus.opcode),
    .funct     (bus.funct),
    .alu_op    (dec_alu_op),
    .imm_sel   (dec_imm_sel),
    .alu_src_b (dec_src_b),
    .legal     (dec_legal)
  );

  assign in_wait = is_mem_wait(state);
  // Fires on the MEM_WAIT_MAX-th consecutive cycle without mem_ready.
  assign timeout = in_wait && !bus.mem_ready && (wait_cnt == 8'(MEM_WAIT_MAX - 1));
  assign retire  = (state == WB_R) || (state == WB_I) || (state == WB_MEM) ||
                   (state == BRANCH) || ((state == MEM_WR) && bus.mem_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH: begin
        if (bus.mem_ready) state_nxt = DECODE;
        else if (timeout)  state_nxt = FETCH;
      end
      DECODE: begin
        if (!dec_legal) state_nxt = FETCH;
        else begin
          case (bus.opcode)
            OP_RTYPE:     state_nxt = EXEC_R;
            OP_LW, OP_SW: state_nxt = MEM_ADDR;
            OP_BEQ:       state_nxt = BRANCH;
            default:      state_nxt = EXEC_I;
          endcase
        end
      end
      EXEC_R:   state_nxt = WB_R;
      EXEC_I:   state_nxt = WB_I;
      WB_R:     state_nxt = FETCH;
      WB_I:     state_nxt = FETCH;
      MEM_ADDR: state_nxt = (bus.opcode == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD: begin
        if (bus.mem_ready) state_nxt = WB_MEM;
        else if (timeout)  state_nxt = FETCH;
      end
      MEM_WR: begin
        if (bus.mem_ready || timeout) state_nxt = FETCH;
      end
      WB_MEM:   state_nxt = FETCH;
      BRANCH:   state_nxt = FETCH;
      default:  state_nxt = FETCH;
    endcase
  end

  // Reset forces every output low combinationally, including the FETCH strobes.
  always_comb begin
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.pc_src     = 1'b0;
    bus.iord       = 1'b0;
    bus.alu_src_b  = 1'b0;
    bus.imm_sel    = '0;
    bus.alu_op     = '0;
    bus.reg_write  = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.illegal_op = 1'b0;
    bus.bus_err    = 1'b0;
    bus.state_dbg  = '0;
    if (rst_n) begin
      bus.state_dbg = state;
      bus.bus_err   = timeout;
      case (state)
        FETCH: begin
          bus.mem_read = 1'b1;
          bus.ir_write = bus.mem_ready;
          bus.pc_write = bus.mem_ready;
        end
        DECODE: bus.illegal_op = !dec_legal;
        EXEC_R, EXEC_I, MEM_ADDR: begin
          bus.alu_src_b = dec_src_b;
          bus.imm_sel   = dec_imm_sel;
          bus.alu_op    = dec_alu_op;
        end
        WB_R: begin
          bus.reg_write = 1'b1;
          bus.reg_dst   = 1'b1;
        end
        WB_I: bus.reg_write = 1'b1;
        MEM_RD: begin
          bus.mem_read = 1'b1;
          bus.iord     = 1'b1;
        end
        MEM_WR: begin
          bus.mem_write = 1'b1;
          bus.iord      = 1'b1;
        end
        WB_MEM: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = 1'b1;
        end
        BRANCH: begin
          bus.alu_src_b = dec_src_b;
          bus.alu_op    = dec_alu_op;
          bus.pc_src    = 1'b1;
          bus.pc_write  = bus.zero;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     wait_cnt <= '0;
    else if (in_wait && !bus.mem_ready && !timeout) wait_cnt <= wait_cnt + 8'd1;
    else                                            wait_cnt <= '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      retired_q <= '0;
    else if (retire) retired_q <= retired_q + CNT_W'(1);
  end

  assign bus.retired = retired_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: reset, directed multicycle sequences, a vector table
// and random instruction streams checked against an instruction-level model.
module tb_mc_ctrl_fsm;

  localparam int unsigned WMAX = 15;
  localparam int unsigned CW   = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mc_ctrl_fsm_if #(.CNT_W(CW)) bus ();

  mc_ctrl_fsm #(.MEM_WAIT_MAX(WMAX), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    int cycles; int nreg; int dst; int m2r; int nill; int npcw;
    int nmr; int nmw; int alu; int imm; int srcb; int ret;
  } res_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       zr;
    int         md;
    res_t       exp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [20:0] all_outs();
    return {bus.mem_read, bus.mem_write, bus.ir_write, bus.pc_write, bus.pc_src,
            bus.iord, bus.alu_src_b, bus.imm_sel, bus.alu_op, bus.reg_write,
            bus.reg_dst, bus.mem_to_reg, bus.illegal_op, bus.bus_err, bus.state_dbg};
  endfunction

  // Instruction-level expectations: cycles after the fetch, strobe counts, EXEC-cycle ALU setup.
  function automatic res_t model(input logic [5:0] op, input logic [5:0] fn,
                                 input logic zr, input int md);
    res_t e;
    bit   lg;
    e  = '{default: 0};
    lg = 1'b1;
    case (op)
      6'h00: begin
        e.cycles = 3; e.nreg = 1; e.dst = 1;
        case (fn)
          6'h20: e.alu = 0;
          6'h22: e.alu = 1;
          6'h24: e.alu = 2;
          6'h25: e.alu = 3;
          6'h2A: e.alu = 4;
          default: lg = 1'b0;
        endcase
      end
      6'h08: begin e.cycles = 3; e.nreg = 1; e.srcb = 1; e.alu = 0; e.imm = 0; end
      6'h0C: begin e.cycles = 3; e.nreg = 1; e.srcb = 1; e.alu = 2; e.imm = 1; end
      6'h0D: begin e.cycles = 3; e.nreg = 1; e.srcb = 1; e.alu = 3; e.imm = 1; end
      6'h0A: begin e.cycles = 3; e.nreg = 1; e.srcb = 1; e.alu = 4; e.imm = 0; end
      6'h0F: begin e.cycles = 3; e.nreg = 1; e.srcb = 1; e.alu = 5; e.imm = 2; end
      6'h23: begin e.cycles = 4 + md; e.nreg = 1; e.m2r = 1; e.nmr = md + 1; e.srcb = 1; end
      6'h2B: begin e.cycles = 3 + md; e.nmw = md + 1; e.srcb = 1; end
      6'h04: begin e.cycles = 2; e.npcw = int'(zr); e.alu = 1; end
      default: lg = 1'b0;
    endcase
    if (!lg) begin
      e = '{default: 0};
      e.cycles = 1;
      e.nill   = 1;
    end else begin
      e.ret = 1;
    end
    return e;
  endfunction

  // Starts in a FETCH cycle; returns once the next FETCH is observed.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic zr,
                           input int fd, input int md, output res_t o);
    int               memc;
    bit               done;
    logic [CW-1:0]    r0;
    o = '{default: 0};
    r0 = '0;
    bus.opcode = op;
    bus.funct  = fn;
    bus.zero   = zr;
    for (int i = 0; i <= fd; i++) begin
      bus.mem_ready = (i == fd);
      #1;
      if (i == fd) begin
        check("fetch_done", {bus.bus_err, bus.ir_write, bus.pc_write, bus.pc_src, bus.iord}, 5'b01100);
        r0 = bus.retired;
      end
      @(negedge clk);
    end
    memc = 0;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      bus.mem_ready = 1'b0;
      #1;
      if (bus.mem_read && !bus.iord) begin
        done = 1'b1;
      end else begin
        if ((bus.mem_read && bus.iord) || bus.mem_write) begin
          bus.mem_ready = (memc == md);
          memc++;
        end
        #1;
        o.cycles++;
        check("rd_wr_excl", bus.mem_read & bus.mem_write, 1'b0);
        if (bus.reg_write) begin
          o.nreg++;
          o.dst = int'(bus.reg_dst);
          o.m2r = int'(bus.mem_to_reg);
        end
        if (bus.illegal_op) o.nill++;
        if (bus.pc_write)   o.npcw++;
        if (bus.mem_read)   o.nmr++;
        if (bus.mem_write)  o.nmw++;
        if (c == 1) begin
          o.alu  = int'(bus.alu_op);
          o.imm  = int'(bus.imm_sel);
          o.srcb = int'(bus.alu_src_b);
        end
        @(negedge clk);
      end
    end
    if (!done) check("instr_bound", 1'b0, 1'b1);
    o.ret = int'(bus.retired - r0);
  endtask

  task automatic cmp(input string tag, input res_t o, input res_t e);
    check({tag, ".cycles"}, o.cycles, e.cycles);
    check({tag, ".nreg"},   o.nreg,   e.nreg);
    check({tag, ".dst"},    o.dst,    e.dst);
    check({tag, ".m2r"},    o.m2r,    e.m2r);
    check({tag, ".nill"},   o.nill,   e.nill);
    check({tag, ".npcw"},   o.npcw,   e.npcw);
    check({tag, ".nmr"},    o.nmr,    e.nmr);
    check({tag, ".nmw"},    o.nmw,    e.nmw);
    check({tag, ".ret"},    o.ret,    e.ret);
    if (e.nill == 0) begin
      check({tag, ".alu"},  o.alu,  e.alu);
      check({tag, ".imm"},  o.imm,  e.imm);
      check({tag, ".srcb"}, o.srcb, e.srcb);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t          tv[$];
    res_t          o;
    logic [CW-1:0] r0;
    logic [5:0]    ops [12];
    logic [5:0]    fns [8];
    logic [5:0]    op, fn;
    logic          zr;

    // fields: cycles nreg dst m2r nill npcw nmr nmw alu imm srcb ret
    tv.push_back('{6'h08, 6'h00, 1'b0, 0, '{3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1}});
    tv.push_back('{6'h0C, 6'h00, 1'b0, 0, '{3, 1, 0, 0, 0, 0, 0, 0, 2, 1, 1, 1}});
    tv.push_back('{6'h0D, 6'h00, 1'b0, 0, '{3, 1, 0, 0, 0, 0, 0, 0, 3, 1, 1, 1}});
    tv.push_back('{6'h0A, 6'h00, 1'b0, 0, '{3, 1, 0, 0, 0, 0, 0, 0, 4, 0, 1, 1}});
    tv.push_back('{6'h0F, 6'h34, 1'b0, 0, '{3, 1, 0, 0, 0, 0, 0, 0, 5, 2, 1, 1}});
    tv.push_back('{6'h00, 6'h20, 1'b0, 0, '{3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1}});
    tv.push_back('{6'h00, 6'h22, 1'b0, 0, '{3, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1}});
    tv.push_back('{6'h00, 6'h24, 1'b0, 0, '{3, 1, 1, 0, 0, 0, 0, 0, 2, 0, 0, 1}});
    tv.push_back('{6'h00, 6'h25, 1'b0, 0, '{3, 1, 1, 0, 0, 0, 0, 0, 3, 0, 0, 1}});
    tv.push_back('{6'h00, 6'h2A, 1'b0, 0, '{3, 1, 1, 0, 0, 0, 0, 0, 4, 0, 0, 1}});
    tv.push_back('{6'h23, 6'h00, 1'b0, 3, '{7, 1, 0, 1, 0, 0, 4, 0, 0, 0, 1, 1}});
    tv.push_back('{6'h2B, 6'h00, 1'b0, 2, '{5, 0, 0, 0, 0, 0, 0, 3, 0, 0, 1, 1}});
    tv.push_back('{6'h04, 6'h03, 1'b1, 0, '{2, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1}});
    tv.push_back('{6'h04, 6'h03, 1'b0, 0, '{2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1}});
    tv.push_back('{6'h3F, 6'h00, 1'b0, 0, '{1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0}});
    tv.push_back('{6'h00, 6'h3F, 1'b0, 0, '{1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0}});
    tv.push_back('{6'h02, 6'h00, 1'b0, 0, '{1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0}});

    bus.opcode    = 6'h00;
    bus.funct     = 6'h00;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    rst_n         = 1'b0;
    #1;
    check("reset_outs", all_outs(), 21'h0);
    check("reset_retired", bus.retired, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // lui 0x3C011234 with mem_ready in the first FETCH cycle
    bus.opcode    = 6'h0F;
    bus.funct     = 6'h34;
    bus.mem_ready = 1'b1;
    #1;
    check("lui_fetch", {bus.mem_read, bus.iord, bus.ir_write, bus.pc_write, bus.pc_src}, 5'b10110);
    r0 = bus.retired;
    check("lui_ret0", r0, 32'd0);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #1;
    check("lui_decode", {bus.mem_read, bus.mem_write, bus.reg_write, bus.pc_write, bus.illegal_op}, 5'b0);
    @(negedge clk);
    #1;
    check("lui_exec", {bus.alu_src_b, bus.imm_sel, bus.alu_op, bus.reg_write}, 7'b1_10_101_0);
    @(negedge clk);
    #1;
    check("lui_wb", {bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.pc_write}, 4'b1000);
    check("lui_wb_ret", bus.retired, 32'd0);
    @(negedge clk);
    #1;
    check("lui_back_fetch", {bus.mem_read, bus.iord}, 2'b10);
    check("lui_ret1", bus.retired, 32'd1);

    foreach (tv[i]) begin
      run_instr(tv[i].op, tv[i].fn, tv[i].zr, i % 3, tv[i].md, o);
      cmp($sformatf("vec%0d", i), o, tv[i].exp);
    end

    // FETCH timeout: mem_ready held low
    r0 = bus.retired;
    bus.mem_ready = 1'b0;
    for (int i = 1; i <= int'(WMAX); i++) begin
      #1;
      check($sformatf("tmo_err_c%0d", i), bus.bus_err, (i == int'(WMAX)));
      check($sformatf("tmo_pcw_c%0d", i), bus.pc_write | bus.ir_write, 1'b0);
      @(negedge clk);
    end
    #1;
    check("tmo_refetch", {bus.mem_read, bus.iord, bus.bus_err}, 3'b100);
    check("tmo_retired", bus.retired, r0);

    // ready on the last allowed cycle wins over the timeout
    run_instr(6'h08, 6'h00, 1'b0, int'(WMAX) - 1, 0, o);
    cmp("edge_ready", o, model(6'h08, 6'h00, 1'b0, 0));

    ops = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h3F, 6'h02, 6'h00};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h3F, 6'h00, 6'h21};
    for (int n = 0; n < 200; n++) begin
      int fd, md;
      op = ops[$urandom_range(0, 11)];
      fn = fns[$urandom_range(0, 7)];
      zr = 1'($urandom_range(0, 1));
      fd = int'($urandom_range(0, 5));
      md = int'($urandom_range(0, 5));
      run_instr(op, fn, zr, fd, md, o);
      cmp($sformatf("rnd%0d_op%0h_fn%0h", n, op, fn), o, model(op, fn, zr, md));
    end

    // reset asserted while in MEM_WR
    check("pre_rst_retired_nonzero", bus.retired != 0, 1'b1);
    bus.opcode    = 6'h2B;
    bus.funct     = 6'h00;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("sw_in_memwr", {bus.mem_write, bus.iord}, 2'b11);
    rst_n = 1'b0;
    #1;
    check("midrst_outs", all_outs(), 21'h0);
    check("midrst_retired", bus.retired, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("postrst_fetch", {bus.mem_read, bus.iord, bus.mem_write}, 3'b100);
    check("postrst_retired", bus.retired, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
